// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: NUM_CH requesters share one data-cache port.
// Grant is registered; selection is fixed-priority or round-robin; in-flight reads can be squashed on flush.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | no transaction outstanding; a grant is chosen and latched
// S_BUSY | latched request driven to the cache until mem_resp_i
module dmem_arbiter #(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter bit          RR     = 1'b1,
    localparam int unsigned BE_W  = DATA_W / 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic [NUM_CH-1:0]        req_read_i,
    input  logic [NUM_CH-1:0]        req_write_i,
    input  logic [NUM_CH*ADDR_W-1:0] req_addr_i,
    input  logic [NUM_CH*DATA_W-1:0] req_wdata_i,
    input  logic [NUM_CH*BE_W-1:0]   req_byte_enable_i,
    output logic [NUM_CH-1:0]        req_resp_o,
    output logic [DATA_W-1:0]        req_rdata_o,
    output logic                     mem_read_o,
    output logic                     mem_write_o,
    output logic [ADDR_W-1:0]        mem_address_o,
    output logic [DATA_W-1:0]        mem_wdata_o,
    output logic [BE_W-1:0]          mem_byte_enable_o,
    input  logic                     mem_resp_i,
    input  logic [DATA_W-1:0]        mem_rdata_i
);

    localparam int unsigned GW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [NUM_CH-1:0] CH_ONE = NUM_CH'(1);

    typedef enum logic {S_IDLE, S_BUSY} state_e;

    state_e            state_q, state_d;
    logic [GW-1:0]     grant_q, grant_d;
    logic [GW-1:0]     last_grant_q, last_grant_d;
    logic              write_q, write_d;
    logic              squash_q, squash_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [BE_W-1:0]   be_q, be_d;

    logic [NUM_CH-1:0] cand;
    logic              found;
    logic [GW-1:0]     sel;
    logic              sel_write;
    int unsigned       scan_idx;
    logic              resp_ok;

    assign cand = req_read_i | req_write_i;

    // Candidate selection; round-robin scans upward from the channel after the last grant.
    always_comb begin
        found    = 1'b0;
        sel      = '0;
        scan_idx = 0;
        if (RR) begin
            for (int k = 1; k <= NUM_CH; k++) begin
                scan_idx = (int'(last_grant_q) + k) % NUM_CH;
                if (!found && ((cand & (CH_ONE << scan_idx)) != '0)) begin
                    found = 1'b1;
                    sel   = GW'(scan_idx);
                end
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (!found && ((cand & (CH_ONE << i)) != '0)) begin
                    found = 1'b1;
                    sel   = GW'(i);
                end
            end
        end
    end

    // A channel raising both read and write is treated as a write.
    assign sel_write = (req_write_i & (CH_ONE << sel)) != '0;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        write_d      = write_q;
        squash_d     = squash_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        be_d         = be_q;
        case (state_q)
            S_IDLE: begin
                squash_d = 1'b0;
                if (found) begin
                    state_d      = S_BUSY;
                    grant_d      = sel;
                    last_grant_d = sel;
                    write_d      = sel_write;
                    addr_d       = ADDR_W'(req_addr_i >> (int'(sel) * ADDR_W));
                    wdata_d      = DATA_W'(req_wdata_i >> (int'(sel) * DATA_W));
                    be_d         = BE_W'(req_byte_enable_i >> (int'(sel) * BE_W));
                end
            end
            S_BUSY: begin
                if (flush_i && !write_q) begin
                    squash_d = 1'b1;
                end
                if (mem_resp_i) begin
                    state_d  = S_IDLE;
                    squash_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q      <= S_IDLE;
            grant_q      <= '0;
            last_grant_q <= GW'(NUM_CH - 1);
            write_q      <= 1'b0;
            squash_q     <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            write_q      <= write_d;
            squash_q     <= squash_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            be_q         <= be_d;
        end
    end

    // A flush landing in the response cycle itself also squashes a read.
    assign resp_ok = rst_i && (state_q == S_BUSY) && mem_resp_i &&
                     (write_q || !(squash_q || flush_i));

    assign req_resp_o        = resp_ok ? (CH_ONE << grant_q) : '0;
    assign req_rdata_o       = mem_rdata_i;
    assign mem_read_o        = (state_q == S_BUSY) && !write_q;
    assign mem_write_o       = (state_q == S_BUSY) && write_q;
    assign mem_address_o     = addr_q;
    assign mem_wdata_o       = wdata_q;
    assign mem_byte_enable_o = be_q;

endmodule
